// File: rtl/box_emitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : box_emitter_if
//  Purpose  : Vertex stream between the box emitter and its consumer.
//  Signals  : vertex       {x,y,z} packed, x in the MSBs
//             color        color of the face owning the current vertex
//             new_triangle first vertex of a triangle
//             valid        vertex/color/new_triangle are meaningful
//             ready        consumer accepts when valid && ready
//  Modports : master (producer side), slave (consumer side)
//  Revision : 1.0 - initial release
// ============================================================================
interface box_emitter_if #(
  parameter int COORD_W = 16,
  parameter int COLOR_W = 16
) ();
  logic [3*COORD_W-1:0] vertex;
  logic [COLOR_W-1:0]   color;
  logic                 new_triangle;
  logic                 valid;
  logic                 ready;

  modport master (output vertex, output color, output new_triangle,
                  output valid, input ready);
  modport slave  (input vertex, input color, input new_triangle,
                  input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/box_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : box_emitter
//  Purpose  : Emits the 12 triangles (36 vertices) of an axis-aligned box,
//             face by face (front,left,right,top,bottom,back), skipping faces
//             disabled by FACE_EN & i_face_mask. Coordinates pass through.
//  Ports    : clk, rst         clock, asynchronous active-high reset
//             i_start          one-cycle emit request (ignored while busy)
//             i_x/y/z_min/max  signed box bounds, sampled at start
//             i_face_mask      runtime face enable, bit0 = front
//             i_face_colors    packed per-face colors, face i at [i*COLOR_W +:]
//             m_out            vertex stream (master modport)
//             o_busy, o_done   emission in progress / one-cycle end pulse
//  Revision : 1.0 - initial release
// ============================================================================
module box_emitter #(
  parameter int         COORD_W = 16,
  parameter int         COLOR_W = 16,
  parameter logic [5:0] FACE_EN = 6'b111111
) (
  input  wire logic                      clk,
  input  wire logic                      rst,
  input  wire logic                      i_start,
  input  wire logic signed [COORD_W-1:0] i_x_min,
  input  wire logic signed [COORD_W-1:0] i_x_max,
  input  wire logic signed [COORD_W-1:0] i_y_min,
  input  wire logic signed [COORD_W-1:0] i_y_max,
  input  wire logic signed [COORD_W-1:0] i_z_min,
  input  wire logic signed [COORD_W-1:0] i_z_max,
  input  wire logic [5:0]                i_face_mask,
  input  wire logic [6*COLOR_W-1:0]      i_face_colors,
  box_emitter_if.master                  m_out,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]           r_state;
  logic [COORD_W-1:0]   r_xn, r_xx, r_yn, r_yx, r_zn, r_zx;
  logic [5:0]           r_mask;
  logic [6*COLOR_W-1:0] r_colors;
  logic [2:0]           r_face;
  logic [2:0]           r_vidx;
  logic [3*COORD_W-1:0] r_vertex;
  logic [COLOR_W-1:0]   r_color;
  logic                 r_new_tri;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_accept;
  logic [3:0]           w_start_find;
  logic [3:0]           w_next_find;
  logic [2:0]           w_idx_inc;

  // Corner selection per face. Front/back walk (x,y); left/right walk (y,z);
  // top/bottom walk (x,z). Each flag picks the max bound for that axis.
  function automatic logic [3*COORD_W-1:0] f_vert(
    input logic [2:0]         face,
    input logic [2:0]         idx,
    input logic [COORD_W-1:0] xn, xx, yn, yx, zn, zx
  );
    logic pa_a, pa_b, pb_a, pb_b;
    logic [COORD_W-1:0] x, y, z;
    pa_a = (idx == 3'd1) || (idx == 3'd4) || (idx == 3'd5);
    pa_b = (idx == 3'd2) || (idx == 3'd3) || (idx == 3'd5);
    pb_a = (idx == 3'd1) || (idx == 3'd2) || (idx == 3'd3);
    pb_b = (idx == 3'd2) || (idx == 3'd3) || (idx == 3'd4);
    case (face)
      3'd0, 3'd5: begin
        x = pa_a ? xx : xn;
        y = pa_b ? yx : yn;
        z = (face == 3'd5) ? zx : zn;
      end
      3'd1, 3'd2: begin
        x = (face == 3'd2) ? xx : xn;
        y = pb_a ? yx : yn;
        z = pb_b ? zx : zn;
      end
      default: begin
        x = pb_a ? xx : xn;
        y = (face == 3'd3) ? yx : yn;
        z = pb_b ? zx : zn;
      end
    endcase
    return {x, y, z};
  endfunction

  // Lowest enabled face at or after 'from'; returns {found, face}.
  function automatic logic [3:0] f_find(input logic [5:0] mask, input logic [3:0] from);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

  always_comb begin
    w_accept     = r_valid & m_out.ready;
    w_start_find = f_find(i_face_mask & FACE_EN, 4'd0);
    w_next_find  = f_find(r_mask, {1'b0, r_face} + 4'd1);
    w_idx_inc    = r_vidx + 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_xn      <= '0;
      r_xx      <= '0;
      r_yn      <= '0;
      r_yx      <= '0;
      r_zn      <= '0;
      r_zx      <= '0;
      r_mask    <= '0;
      r_colors  <= '0;
      r_face    <= '0;
      r_vidx    <= '0;
      r_vertex  <= '0;
      r_color   <= '0;
      r_new_tri <= 1'b0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_xn     <= i_x_min;
            r_xx     <= i_x_max;
            r_yn     <= i_y_min;
            r_yx     <= i_y_max;
            r_zn     <= i_z_min;
            r_zx     <= i_z_max;
            r_mask   <= i_face_mask & FACE_EN;
            r_colors <= i_face_colors;
            if (w_start_find[3]) begin
              // First vertex is built straight from the inputs so it is
              // valid the cycle after acceptance.
              r_state   <= S_EMIT;
              r_busy    <= 1'b1;
              r_valid   <= 1'b1;
              r_face    <= w_start_find[2:0];
              r_vidx    <= 3'd0;
              r_new_tri <= 1'b1;
              r_vertex  <= f_vert(w_start_find[2:0], 3'd0, i_x_min, i_x_max,
                                  i_y_min, i_y_max, i_z_min, i_z_max);
              r_color   <= i_face_colors[w_start_find[2:0]*COLOR_W +: COLOR_W];
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        default: begin
          if (w_accept) begin
            if (r_vidx != 3'd5) begin
              r_vidx    <= w_idx_inc;
              r_new_tri <= (w_idx_inc == 3'd3);
              r_vertex  <= f_vert(r_face, w_idx_inc, r_xn, r_xx, r_yn, r_yx, r_zn, r_zx);
            end else if (w_next_find[3]) begin
              r_face    <= w_next_find[2:0];
              r_vidx    <= 3'd0;
              r_new_tri <= 1'b1;
              r_vertex  <= f_vert(w_next_find[2:0], 3'd0, r_xn, r_xx, r_yn, r_yx, r_zn, r_zx);
              r_color   <= r_colors[w_next_find[2:0]*COLOR_W +: COLOR_W];
            end else begin
              r_state   <= S_IDLE;
              r_valid   <= 1'b0;
              r_new_tri <= 1'b0;
              r_busy    <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign m_out.vertex       = r_vertex;
  assign m_out.color        = r_color;
  assign m_out.new_triangle = r_new_tri;
  assign m_out.valid        = r_valid;
  assign o_busy             = r_busy;
  assign o_done             = r_done;

endmodule
`default_nettype wire

// File: tb/tb_box_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_box_emitter
//  Purpose  : Self-checking bench for box_emitter: table of emission cases
//             plus hand sequences for reset, restart-on-done and FACE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_box_emitter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_start = 1'b0;
  logic i_start2 = 1'b0;
  logic signed [15:0] xn = -16, xx = 16, yn = -64, yx = -32, zn = 176, zx = 208;
  logic [5:0]  i_face_mask = 6'b0;
  logic [95:0] i_face_colors;
  logic        busy, done, busy2, done2;

  always #5 clk = ~clk;

  box_emitter_if #(.COORD_W(16), .COLOR_W(16)) bus ();
  box_emitter_if #(.COORD_W(16), .COLOR_W(16)) bus2 ();

  box_emitter #(.COORD_W(16), .COLOR_W(16), .FACE_EN(6'b111111)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_x_min(xn), .i_x_max(xx), .i_y_min(yn), .i_y_max(yx), .i_z_min(zn), .i_z_max(zx),
    .i_face_mask(i_face_mask), .i_face_colors(i_face_colors),
    .m_out(bus), .o_busy(busy), .o_done(done));

  box_emitter #(.COORD_W(16), .COLOR_W(16), .FACE_EN(6'b000001)) dut2 (
    .clk(clk), .rst(rst), .i_start(i_start2),
    .i_x_min(xn), .i_x_max(xx), .i_y_min(yn), .i_y_max(yx), .i_z_min(zn), .i_z_max(zx),
    .i_face_mask(i_face_mask), .i_face_colors(i_face_colors),
    .m_out(bus2), .o_busy(busy2), .o_done(done2));

  typedef struct {
    logic [47:0] v;
    logic [15:0] c;
    logic        nt;
  } vtx_t;

  typedef struct {
    logic [5:0] mask;
    int         rmode;   // 0: ready held 1, 1: ready 1,0,0 repeating
    bit         pulse;   // stray starts at cycles 5 and 10
    int         exp_count;
    int         exp_nt;
  } tcase_t;

  int checks = 0;
  int failures = 0;
  vtx_t exp_q[$];
  logic [47:0] first_v;
  int fbA[6] = '{0, 1, 0, 0, 1, 1};
  int fbB[6] = '{0, 0, 1, 1, 0, 1};
  int lrA[6] = '{0, 1, 1, 1, 0, 0};
  int lrB[6] = '{0, 0, 1, 1, 1, 0};

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic build_model(input logic [5:0] m);
    logic signed [15:0] x, y, z;
    vtx_t e;
    exp_q.delete();
    for (int f = 0; f < 6; f++) begin
      if (m[f]) begin
        for (int k = 0; k < 6; k++) begin
          case (f)
            0, 5: begin
              x = fbA[k] != 0 ? xx : xn; y = fbB[k] != 0 ? yx : yn; z = (f == 5) ? zx : zn;
            end
            1, 2: begin
              x = (f == 2) ? xx : xn; y = lrA[k] != 0 ? yx : yn; z = lrB[k] != 0 ? zx : zn;
            end
            default: begin
              y = (f == 3) ? yx : yn; x = lrA[k] != 0 ? xx : xn; z = lrB[k] != 0 ? zx : zn;
            end
          endcase
          e.v  = {x, y, z};
          e.c  = 16'h1401 + 16'(f);
          e.nt = (k == 0) || (k == 3);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic do_emit(input logic [5:0] mask, input int rmode, input bit pulse,
                         input int exp_count, input int exp_nt, input string nm);
    int n, nt;
    bit fin, rdy;
    build_model(mask);
    n = 0; nt = 0; fin = 0;
    @(negedge clk);
    i_face_mask = mask;
    i_start = 1'b1;
    bus.ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    i_face_mask = 6'b000001;
    for (int c = 0; c < 300 && !fin; c++) begin
      rdy = (rmode == 0) ? 1'b1 : ((c % 3) == 0);
      bus.ready = rdy;
      if (pulse) i_start = (c == 5) || (c == 10);
      if (n < exp_q.size()) begin
        if (n == 0) first_v = bus.vertex;
        if (!(bus.valid && busy && bus.vertex == exp_q[n].v && bus.color == exp_q[n].c
              && bus.new_triangle == exp_q[n].nt)) begin
          chk(1'b0, {nm, "_vtx"}, {7'd0, bus.valid, bus.new_triangle, bus.color[6:0], bus.vertex},
              {8'd1, exp_q[n].nt, exp_q[n].c[6:0], exp_q[n].v});
          fin = 1;
        end else begin
          checks++;
          if (rdy) begin
            if (bus.new_triangle) nt++;
            n++;
          end
        end
      end else begin
        chk(done && !bus.valid && !busy, {nm, "_done"}, {61'd0, done, bus.valid, busy}, 64'b100);
        fin = 1;
      end
      @(negedge clk);
    end
    i_start = 1'b0;
    chk(fin, {nm, "_timeout"}, 64'(fin), 64'd1);
    chk(n == exp_count, {nm, "_count"}, 64'(n), 64'(exp_count));
    chk(nt == exp_nt, {nm, "_ntcount"}, 64'(nt), 64'(exp_nt));
    for (int k = 0; k < 3; k++) begin
      chk(!done && !bus.valid && !busy, {nm, "_after"}, {61'd0, done, bus.valid, busy}, 64'd0);
      @(negedge clk);
    end
  endtask

  tcase_t tc[6];

  initial begin
    for (int f = 0; f < 6; f++) i_face_colors[f*16 +: 16] = 16'h1401 + 16'(f);
    bus.ready = 1'b1;
    bus2.ready = 1'b1;
    tc[0] = '{6'b111111, 0, 1'b0, 36, 12};
    tc[1] = '{6'b001000, 0, 1'b0, 6, 2};
    tc[2] = '{6'b111111, 1, 1'b0, 36, 12};
    tc[3] = '{6'b100001, 0, 1'b0, 12, 4};
    tc[4] = '{6'b010110, 1, 1'b0, 18, 6};
    tc[5] = '{6'b111111, 0, 1'b1, 36, 12};

    // Reset state
    repeat (3) @(negedge clk);
    chk(!bus.valid && !busy && !done && !bus.new_triangle && bus.vertex == 48'd0 && bus.color == 16'd0,
        "reset_state", {bus.vertex, bus.color}, 64'd0);
    chk(!bus2.valid && !busy2 && !done2, "reset_state2", {61'd0, bus2.valid, busy2, done2}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_emit(tc[i].mask, tc[i].rmode, tc[i].pulse, tc[i].exp_count, tc[i].exp_nt, $sformatf("case%0d", i));
      if (i == 0) chk(first_v == {16'hFFF0, 16'hFFC0, 16'd176}, "first_vertex", 64'(first_v),
                      {16'd0, 16'hFFF0, 16'hFFC0, 16'd176});
    end

    // Empty mask: no vertices, done the cycle after start
    do_emit(6'b000000, 0, 1'b0, 0, 0, "mask0");

    // FACE_EN=000001 with mask 111110: nothing enabled
    @(negedge clk);
    i_face_mask = 6'b111110;
    i_start2 = 1'b1;
    @(negedge clk);
    i_start2 = 1'b0;
    chk(done2 && !busy2 && !bus2.valid, "faceen_done", {61'd0, done2, busy2, bus2.valid}, 64'b100);
    @(negedge clk);
    chk(!done2 && !bus2.valid, "faceen_after", {62'd0, done2, bus2.valid}, 64'd0);

    // Start in the same cycle as done is accepted
    build_model(6'b000001);
    @(negedge clk);
    i_face_mask = 6'b001000;
    i_start = 1'b1;
    bus.ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    begin
      int b = 0;
      while (!done && b < 20) begin @(negedge clk); b++; end
      chk(b == 6, "restart_done_time", 64'(b), 64'd6);
    end
    i_face_mask = 6'b000001;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk(bus.valid && busy && bus.vertex == exp_q[0].v && bus.color == 16'h1401, "restart_on_done",
        {bus.color, bus.vertex}, {16'h1401, exp_q[0].v});
    begin
      int b = 0;
      while (!done && b < 20) begin @(negedge clk); b++; end
      chk(done, "restart_finish", 64'(done), 64'd1);
    end

    // Asynchronous reset mid-emission after vertex 17
    build_model(6'b111111);
    @(negedge clk);
    i_face_mask = 6'b111111;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (17) @(negedge clk);
    chk(bus.valid && bus.vertex == exp_q[17].v, "vertex17", 64'(bus.vertex), 64'(exp_q[17].v));
    #2 rst = 1'b1;
    #1;
    chk(!bus.valid && !busy && !done && !bus.new_triangle && bus.vertex == 48'd0 && bus.color == 16'd0,
        "async_reset", {bus.vertex, bus.color}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_emit(6'b111111, 0, 1'b0, 36, 12, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
